add64_slice_seq: RTL and testbench

//  Multi-cycle 64-bit add/subtract sequencer built around one shared adder16 slice.

---
 rtl/add64_slice_seq_pkg.sv | 15 +
 rtl/add64_slice_seq_adder16.sv | 12 +
 rtl/add64_slice_seq.sv | 111 +++++++++++
 tb/tb_add64_slice_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/add64_slice_seq_pkg.sv
// Shared definitions for the slice-stepped add/subtract sequencer.
package add_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 16;
  localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;
  localparam int IDXW      = $clog2(NSLICE);

endpackage

// File: rtl/add64_slice_seq_adder16.sv
// Shared 16-bit ripple slice: sum and carry-out of a + b + cin.
module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/add64_slice_seq.sv
// Multi-cycle WIDTH-bit add/subtract that steps one adder16 across the operands,
// LSB slice first, chaining slices through a registered carry.
//
//  state  | meaning
//  S_IDLE | waiting for a request; in_ready high
//  S_RUN  | one slice per cycle, idx selects the slice
//  S_DONE | result valid, held until out_ready
module add64_slice_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  if ((WIDTH % SLICE) != 0 || SLICE != 16) begin : g_bad_cfg
    $error("add64_slice_seq: WIDTH must be a multiple of SLICE and SLICE must be 16");
  end

  state_t            state;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [SLICE-1:0]  sl_a;
  logic [SLICE-1:0]  sl_b;
  logic [SLICE-1:0]  sl_sum;
  logic              sl_cout;

  always_comb begin
    sl_a = opa[int'(idx)*SLICE +: SLICE];
    sl_b = opb[int'(idx)*SLICE +: SLICE];
  end

  adder16 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: the +1 enters as the first slice's carry-in.
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= sub;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[int'(idx)*SLICE +: SLICE] <= sl_sum;
          carry <= sl_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout      <= sl_cout;
            overflow  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (sl_sum[SLICE-1] != opa[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add64_slice_seq.sv
// Directed and random checks for the slice-stepped add/subtract sequencer.
module tb_add64_slice_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout, overflow, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add64_slice_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present a request at the negedge, take it on the next edge, count edges to out_valid.
  task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic isub,
                       output int lat);
    @(negedge clk);
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ia; b = ~ib; sub = ~isub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen_valid;
    logic [63:0] held;
    logic [64:0] ref65;
    logic [63:0] ra, rb, rbb;
    logic        rs, rv;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[5] = '{64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[6] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[9] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst out_valid", 64'(out_valid), 64'h0);
    chk("rst sum", sum, 64'h0);
    chk("rst cout", 64'(cout), 64'h0);
    chk("rst overflow", 64'(overflow), 64'h0);
    chk("rst in_ready", 64'(in_ready), 64'h1);
    chk("rst busy", 64'(busy), 64'h0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'd4);
      chk($sformatf("v%0d sum", i), sum, vecs[i].s);
      chk($sformatf("v%0d cout", i), 64'(cout), 64'(vecs[i].c));
      chk($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].v));
      chk($sformatf("v%0d in_ready done", i), 64'(in_ready), 64'h0);
      handshake();
      chk($sformatf("v%0d valid drop", i), 64'(out_valid), 64'h0);
      chk($sformatf("v%0d sum after hs", i), sum, vecs[i].s);
    end

    // Backpressure with a pending second request.
    issue(vecs[1].a, vecs[1].b, vecs[1].sub, lat);
    chk("bp latency", 64'(lat), 64'd4);
    held = sum;
    @(negedge clk);
    a = vecs[4].a; b = vecs[4].b; sub = vecs[4].sub; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold sum %0d", k), sum, vecs[1].s);
      chk($sformatf("bp hold valid %0d", k), 64'(out_valid), 64'h1);
      chk($sformatf("bp in_ready %0d", k), 64'(in_ready), 64'h0);
    end
    chk("bp held", held, vecs[1].s);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp idle in_ready", 64'(in_ready), 64'h1);
    chk("bp idle valid", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    chk("bp second accepted", 64'(busy), 64'h1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2 latency", 64'(lat), 64'd4);
    chk("bp2 sum", sum, vecs[4].s);
    chk("bp2 cout", 64'(cout), 64'h0);
    handshake();

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    a = vecs[0].a; b = vecs[0].b; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen_valid = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    chk("midrun no valid", 64'(seen_valid), 64'h0);
    chk("midrun sum", sum, 64'h0);
    chk("midrun cout", 64'(cout), 64'h0);
    chk("midrun overflow", 64'(overflow), 64'h0);
    chk("midrun in_ready", 64'(in_ready), 64'h1);
    issue(vecs[4].a, vecs[4].b, vecs[4].sub, lat);
    chk("post-rst latency", 64'(lat), 64'd4);
    chk("post-rst sum", sum, 64'h2222_2222_2222_2211);
    chk("post-rst cout", 64'(cout), 64'h0);
    handshake();

    // Random operands against a 65-bit reference.
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(1, 0));
      rbb = rb ^ {64{rs}};
      ref65 = {1'b0, ra} + {1'b0, rbb} + {64'b0, rs};
      rv = (ra[63] == rbb[63]) && (ref65[63] != ra[63]);
      issue(ra, rb, rs, lat);
      total++;
      if (lat != 4 || sum !== ref65[63:0] || cout !== ref65[64] || overflow !== rv) begin
        bad++;
        $display("FAIL rand %0d: a=%h b=%h sub=%0d got sum=%h c=%0d v=%0d lat=%0d expected sum=%h c=%0d v=%0d lat=4",
                 n, ra, rb, rs, sum, cout, overflow, lat, ref65[63:0], ref65[64], rv);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "random mismatch");
      end
      handshake();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
